rr_multi_picker: RTL

- Parametrised N-requester, K-grant rotating-priority selector for issue/wakeup select.
- Each cycle, picks up to K active requests in circular order from a rotating pointer.
- Selection is registered and presented through a valid/ready output stage.
- Replaces fixed MSB/LSB priority selection with a fair, multi-grant, back-pressurable picker.

---
 rtl/rr_picker_pkg.sv | 18 +
 rtl/rr_multi_picker_find.sv | 29 ++
 rtl/rr_multi_picker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rr_picker_pkg.sv
// Shared helpers for the rotating-priority multi-grant picker.
// Optional urgent-first selection is enabled with RR_PICKER_URGENT_EN.
package rr_picker_pkg;

  localparam int SLOT_IDX_W = 16;

  // Generic grant slot; users take the low IDX_W bits of idx for their N.
  typedef struct packed {
    logic                  valid;
    logic [SLOT_IDX_W-1:0] idx;
  } grant_slot_t;

  // Modular increment that also wraps correctly for non-power-of-two n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_multi_picker_find.sv
// Circular first-set-bit search: scans start, start+1, ..., wrapping mod N.
module circ_find_first #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W:0] pos;

  // Scan from the far end back toward start so the closest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, start} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (vec[pos[IDX_W-1:0]]) begin
        idx   = pos[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_multi_picker.sv
// N-requester, K-grant rotating-priority picker with a registered valid/ready output.
// Define RR_PICKER_URGENT_EN to add urgent_i, whose requests are served ahead of the rest.
module rr_multi_picker
  import rr_picker_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int K     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             grant_ready_i,
`ifdef RR_PICKER_URGENT_EN
  input  logic [N-1:0]     urgent_i,
`endif
  output logic [K-1:0]       grant_valid_o,
  output logic [K*IDX_W-1:0] grant_idx_o,
  output logic [N-1:0]       grant_onehot_o,
  output logic [IDX_W-1:0]   ptr_o,
  output logic               any_req_o
);

  logic [K-1:0]         valid_reg;
  logic [K*IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]     ptr_reg;
  logic [IDX_W-1:0]     ptr_next;
  logic [N-1:0]         onehot;
  logic [N-1:0]         eff;
  logic [K-1:0]         sel_found;
  logic [K*IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]     last_idx;
  logic                 load;
  logic [K-1:0][N-1:0]  nrm_vec;

  always_comb begin
    onehot = '0;
    for (int s = 0; s < K; s++) begin
      if (valid_reg[s]) onehot = onehot | (N'(1) << idx_reg[s*IDX_W +: IDX_W]);
    end
  end

  // Requesters already holding a grant must not be picked again.
  assign eff  = req_i & ~(valid_reg[0] ? onehot : '0);
  assign load = !valid_reg[0] || grant_ready_i;

`ifdef RR_PICKER_URGENT_EN
  logic [K-1:0][N-1:0] urg_vec;
  assign urg_vec[0] = eff & urgent_i;
  assign nrm_vec[0] = eff & ~urgent_i;
`else
  assign nrm_vec[0] = eff;
`endif

  genvar gi;
  for (gi = 0; gi < K; gi++) begin : g_stage
    logic [IDX_W-1:0] n_idx;
    logic             n_found;

    circ_find_first #(.N(N), .IDX_W(IDX_W)) u_nrm (
      .vec   (nrm_vec[gi]),
      .start (ptr_reg),
      .idx   (n_idx),
      .found (n_found)
    );

`ifdef RR_PICKER_URGENT_EN
    logic [IDX_W-1:0] u_idx;
    logic             u_found;

    circ_find_first #(.N(N), .IDX_W(IDX_W)) u_urg (
      .vec   (urg_vec[gi]),
      .start (ptr_reg),
      .idx   (u_idx),
      .found (u_found)
    );

    assign sel_found[gi]                = u_found | n_found;
    assign sel_idx[gi*IDX_W +: IDX_W]   = u_found ? u_idx : n_idx;
`else
    assign sel_found[gi]                = n_found;
    assign sel_idx[gi*IDX_W +: IDX_W]   = n_idx;
`endif

    // The next stage sees this stage's winner removed.
    if (gi < K - 1) begin : g_mask
      logic [N-1:0] win_mask;
      assign win_mask = sel_found[gi] ? (N'(1) << sel_idx[gi*IDX_W +: IDX_W]) : '0;
      assign nrm_vec[gi+1] = nrm_vec[gi] & ~win_mask;
`ifdef RR_PICKER_URGENT_EN
      assign urg_vec[gi+1] = urg_vec[gi] & ~win_mask;
`endif
    end
  end

  always_comb begin
    last_idx = '0;
    for (int s = 0; s < K; s++) begin
      if (sel_found[s]) last_idx = sel_idx[s*IDX_W +: IDX_W];
    end
  end

  assign ptr_next = IDX_W'(wrap_inc(int'(last_idx), N));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= '0;
      idx_reg   <= '0;
      ptr_reg   <= '0;
    end else if (load) begin
      valid_reg <= sel_found;
      idx_reg   <= sel_idx;
      if (sel_found[0]) ptr_reg <= ptr_next;
    end
  end

  assign grant_valid_o  = valid_reg;
  assign grant_idx_o    = idx_reg;
  assign grant_onehot_o = onehot;
  assign ptr_o          = ptr_reg;
  assign any_req_o      = |req_i;

endmodule
